// File: rtl/uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// uart_tx_scheduler
//
// Round-robin scheduler in front of the UART transmitter. It accepts bytes
// from two producers, issues a single-cycle Data_Valid strobe with the byte
// and its parity configuration, then follows the transmitter's busy flag
// until the frame is finished. Completed frames are counted. A transmitter
// that never raises busy after a strobe sets a sticky timeout flag.
//
// Ports
//   CLK, RST                   clock, synchronous active-high reset
//   REQ0_DATA/VALID/READY      requester 0 byte handshake
//   REQ1_DATA/VALID/READY      requester 1 byte handshake
//   CFG_PAR_EN, CFG_PAR_TYP    parity configuration, sampled at accept
//   TX_BUSY                    transmitter busy flag
//   TX_P_DATA, TX_DATA_VALID   byte and one-cycle strobe to the transmitter
//   TX_PAR_EN, TX_PAR_TYP      parity configuration latched at accept
//   GRANT_ID                   requester owning the current/last frame
//   FRAME_CNT                  completed-frame counter, wraps
//   ERR_TIMEOUT                sticky: busy never rose after a strobe
// ---------------------------------------------------------------------------
module uart_tx_scheduler #(
    parameter int DATA_W       = 8,
    parameter int CNT_W        = 16,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] REQ0_DATA,
    input  logic              REQ0_VALID,
    output logic              REQ0_READY,
    input  logic [DATA_W-1:0] REQ1_DATA,
    input  logic              REQ1_VALID,
    output logic              REQ1_READY,
    input  logic              CFG_PAR_EN,
    input  logic              CFG_PAR_TYP,
    input  logic              TX_BUSY,
    output logic [DATA_W-1:0] TX_P_DATA,
    output logic              TX_DATA_VALID,
    output logic              TX_PAR_EN,
    output logic              TX_PAR_TYP,
    output logic              GRANT_ID,
    output logic [CNT_W-1:0]  FRAME_CNT,
    output logic              ERR_TIMEOUT
);

    // Wide enough to hold 0 .. BUSY_TIMEOUT-1.
    localparam int TW = $clog2(BUSY_TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            rr_ptr;       // last granted requester
    logic            sel;          // round-robin choice for this cycle
    logic            grant_ok;
    logic            accept;
    logic            tmo_expired;
    logic            frame_done;
    logic [TW-1:0]   tmo_cnt;

    // Arbitration and handshake. READY depends on TX_BUSY combinationally so
    // that a transmitter still busy from an abandoned frame blocks grants.
    always_comb begin
        // NOTE: every signal gets a default before any branch; a path that
        // leaves one unassigned would infer a latch.
        sel        = REQ1_VALID;
        if (REQ0_VALID && REQ1_VALID) begin
            sel = ~rr_ptr;
        end
        grant_ok   = (state == IDLE) && !TX_BUSY && !RST;
        REQ0_READY = grant_ok && !sel;
        REQ1_READY = grant_ok &&  sel;
        accept     = (REQ0_VALID && REQ0_READY) || (REQ1_VALID && REQ1_READY);
    end

    // Next-state logic.
    always_comb begin
        state_nxt   = state;
        tmo_expired = 1'b0;
        frame_done  = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = STROBE;
                end
            end
            STROBE: begin
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (TX_BUSY) begin
                    state_nxt = WAIT_DONE;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_expired = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!TX_BUSY) begin
                    frame_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (RST) begin
            state         <= IDLE;
            rr_ptr        <= 1'b1;
            tmo_cnt       <= '0;
            TX_P_DATA     <= '0;
            TX_DATA_VALID <= 1'b0;
            TX_PAR_EN     <= 1'b0;
            TX_PAR_TYP    <= 1'b0;
            GRANT_ID      <= 1'b0;
            FRAME_CNT     <= '0;
            ERR_TIMEOUT   <= 1'b0;
        end else begin
            state         <= state_nxt;
            // Accept only happens in IDLE, so this is high exactly in STROBE.
            TX_DATA_VALID <= accept;

            if (accept) begin
                TX_P_DATA  <= sel ? REQ1_DATA : REQ0_DATA;
                TX_PAR_EN  <= CFG_PAR_EN;
                TX_PAR_TYP <= CFG_PAR_TYP;
                GRANT_ID   <= sel;
                rr_ptr     <= sel;
            end

            // Counter is zero on the first WAIT_BUSY cycle; the wrap after
            // the last count is harmless because the state leaves WAIT_BUSY.
            if (state == STROBE) begin
                tmo_cnt <= '0;
            end else if (state == WAIT_BUSY && !TX_BUSY) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (tmo_expired) begin
                ERR_TIMEOUT <= 1'b1;
            end
            if (frame_done) begin
                FRAME_CNT <= FRAME_CNT + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_scheduler
//
// Directed bench for uart_tx_scheduler. Expected frames are queued when a
// request is issued; a monitor pops and compares on every TX_DATA_VALID
// strobe. A small transmitter model raises busy one cycle after a strobe.
// ---------------------------------------------------------------------------
module tb_uart_tx_scheduler;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 3;
    localparam int BT     = 4;

    logic              CLK = 1'b0;
    logic              RST;
    logic [DATA_W-1:0] REQ0_DATA, REQ1_DATA;
    logic              REQ0_VALID, REQ1_VALID;
    logic              REQ0_READY, REQ1_READY;
    logic              CFG_PAR_EN, CFG_PAR_TYP;
    logic              TX_BUSY;
    logic [DATA_W-1:0] TX_P_DATA;
    logic              TX_DATA_VALID, TX_PAR_EN, TX_PAR_TYP, GRANT_ID;
    logic [CNT_W-1:0]  FRAME_CNT;
    logic              ERR_TIMEOUT;

    uart_tx_scheduler #(
        .DATA_W      (DATA_W),
        .CNT_W       (CNT_W),
        .BUSY_TIMEOUT(BT)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .REQ0_DATA    (REQ0_DATA),
        .REQ0_VALID   (REQ0_VALID),
        .REQ0_READY   (REQ0_READY),
        .REQ1_DATA    (REQ1_DATA),
        .REQ1_VALID   (REQ1_VALID),
        .REQ1_READY   (REQ1_READY),
        .CFG_PAR_EN   (CFG_PAR_EN),
        .CFG_PAR_TYP  (CFG_PAR_TYP),
        .TX_BUSY      (TX_BUSY),
        .TX_P_DATA    (TX_P_DATA),
        .TX_DATA_VALID(TX_DATA_VALID),
        .TX_PAR_EN    (TX_PAR_EN),
        .TX_PAR_TYP   (TX_PAR_TYP),
        .GRANT_ID     (GRANT_ID),
        .FRAME_CNT    (FRAME_CNT),
        .ERR_TIMEOUT  (ERR_TIMEOUT)
    );

    always #5 CLK = ~CLK;

    // Transmitter model: busy from strobe+1 for busy_len cycles.
    logic model_busy = 1'b0;
    logic force_busy = 1'b0;
    bit   model_en   = 1'b0;
    int   busy_len   = 11;
    int   busy_rem   = 0;
    assign TX_BUSY = model_busy | force_busy;

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (!model_en) busy_rem = 0;
            if (busy_rem > 0) begin
                model_busy = 1'b1;
                busy_rem   = busy_rem - 1;
            end else begin
                model_busy = 1'b0;
            end
            if (model_en && TX_DATA_VALID) busy_rem = busy_len;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              par_en;
        logic              par_typ;
        logic              grant;
    } frame_t;

    frame_t exp_q[$];

    task automatic push(input logic [DATA_W-1:0] d, input logic en, input logic typ, input logic g);
        frame_t f;
        f.data    = d;
        f.par_en  = en;
        f.par_typ = typ;
        f.grant   = g;
        exp_q.push_back(f);
    endtask

    // Monitor / scoreboard.
    int   cyc             = 0;
    int   n_strobe        = 0;
    int   last_strobe_cyc = 0;
    int   prev_strobe_cyc = 0;
    logic dv_prev         = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        frame_t e;
        forever begin
            @(negedge CLK);
            check("ready_exclusive", 32'(REQ0_READY & REQ1_READY), 32'd0);
            if (TX_DATA_VALID) begin
                check("strobe_width", 32'(dv_prev), 32'd0);
                n_strobe++;
                prev_strobe_cyc = last_strobe_cyc;
                last_strobe_cyc = cyc;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected: strobe data 0x%0h, no frame expected", TX_P_DATA);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_data",    32'(TX_P_DATA),  32'(e.data));
                    check("sb_par_en",  32'(TX_PAR_EN),  32'(e.par_en));
                    check("sb_par_typ", 32'(TX_PAR_TYP), 32'(e.par_typ));
                    check("sb_grant",   32'(GRANT_ID),   32'(e.grant));
                end
            end
            dv_prev = TX_DATA_VALID;
        end
    end

    // Helpers: main process acts 1 time unit after each rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_ready(input bit n, input int lim, input string name);
        int i = 0;
        #1;
        while (((n ? REQ1_READY : REQ0_READY) !== 1'b1) && i < lim) begin
            tick();
            i++;
        end
        check(name, 32'(n ? REQ1_READY : REQ0_READY), 32'd1);
    endtask

    task automatic wait_cnt(input logic [CNT_W-1:0] v, input int lim, input string name);
        int i = 0;
        while (FRAME_CNT !== v && i < lim) begin
            tick();
            i++;
        end
        check(name, 32'(FRAME_CNT), 32'(v));
    endtask

    task automatic wait_strobes(input int target, input int lim, input string name);
        int i = 0;
        while (n_strobe < target && i < lim) begin
            tick();
            i++;
        end
        check(name, 32'(n_strobe), 32'(target));
    endtask

    task automatic pulse_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dv"},      32'(TX_DATA_VALID), 32'd0);
        check({tag, "_p_data"},  32'(TX_P_DATA),     32'd0);
        check({tag, "_par_en"},  32'(TX_PAR_EN),     32'd0);
        check({tag, "_par_typ"}, 32'(TX_PAR_TYP),    32'd0);
        check({tag, "_grant"},   32'(GRANT_ID),      32'd0);
        check({tag, "_cnt"},     32'(FRAME_CNT),     32'd0);
        check({tag, "_err"},     32'(ERR_TIMEOUT),   32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int base;

    initial begin
        RST         = 1'b1;
        REQ0_DATA   = 8'hA5;
        REQ1_DATA   = 8'h00;
        REQ0_VALID  = 1'b1;
        REQ1_VALID  = 1'b1;
        CFG_PAR_EN  = 1'b0;
        CFG_PAR_TYP = 1'b0;

        // Reset: READY held low while RST is high, registers cleared.
        tick();
        tick();
        check("rst_ready0", 32'(REQ0_READY), 32'd0);
        check("rst_ready1", 32'(REQ1_READY), 32'd0);
        check_all_zero("rst");
        REQ0_VALID = 1'b0;
        REQ1_VALID = 1'b0;
        RST        = 1'b0;

        // Single frame with parity on.
        model_en    = 1'b1;
        busy_len    = 11;
        CFG_PAR_EN  = 1'b1;
        CFG_PAR_TYP = 1'b1;
        push(8'hA5, 1'b1, 1'b1, 1'b0);
        REQ0_VALID  = 1'b1;
        wait_ready(1'b0, 10, "t1_ready0");
        tick();
        REQ0_VALID  = 1'b0;
        CFG_PAR_EN  = 1'b0;
        CFG_PAR_TYP = 1'b0;
        check("t1_strobe_T+1", 32'(TX_DATA_VALID), 32'd1);
        tick();
        check("t1_strobe_low", 32'(TX_DATA_VALID), 32'd0);
        wait_cnt(3'd1, 40, "t1_frame_cnt");
        check("t1_grant",   32'(GRANT_ID),   32'd0);
        check("t1_p_data",  32'(TX_P_DATA),  32'hA5);
        check("t1_par_en",  32'(TX_PAR_EN),  32'd1);
        check("t1_par_typ", 32'(TX_PAR_TYP), 32'd1);

        // Round-robin contention: requester 0 first after reset.
        pulse_reset();
        push(8'h11, 1'b0, 1'b0, 1'b0);
        push(8'h22, 1'b0, 1'b0, 1'b1);
        push(8'h11, 1'b0, 1'b0, 1'b0);
        push(8'h22, 1'b0, 1'b0, 1'b1);
        base       = n_strobe;
        REQ0_DATA  = 8'h11;
        REQ1_DATA  = 8'h22;
        REQ0_VALID = 1'b1;
        REQ1_VALID = 1'b1;
        wait_strobes(base + 4, 200, "t2_strobes");
        REQ0_VALID = 1'b0;
        REQ1_VALID = 1'b0;
        wait_cnt(3'd4, 40, "t2_frame_cnt");
        check("t2_sb_empty", 32'(exp_q.size()), 32'd0);

        // Back-to-back from requester 1; CFG change mid-frame is ignored.
        CFG_PAR_EN  = 1'b1;
        CFG_PAR_TYP = 1'b0;
        REQ1_DATA   = 8'h77;
        push(8'h77, 1'b1, 1'b0, 1'b1);
        push(8'h78, 1'b0, 1'b1, 1'b1);
        base        = n_strobe;
        REQ1_VALID  = 1'b1;
        wait_strobes(base + 1, 20, "t3_first_strobe");
        CFG_PAR_EN  = 1'b0;
        CFG_PAR_TYP = 1'b1;
        REQ1_DATA   = 8'h78;
        tick();
        check("t3_par_en_hold",  32'(TX_PAR_EN),  32'd1);
        check("t3_par_typ_hold", 32'(TX_PAR_TYP), 32'd0);
        wait_strobes(base + 2, 40, "t3_second_strobe");
        REQ1_VALID = 1'b0;
        // busy strobe+1..strobe+11, low at U=strobe+12, next strobe U+2.
        check("t3_gap", 32'(last_strobe_cyc - prev_strobe_cyc), 32'd14);
        wait_cnt(3'd6, 40, "t3_frame_cnt");

        // Timeout: transmitter never raises busy.
        pulse_reset();
        model_en    = 1'b0;
        CFG_PAR_EN  = 1'b0;
        CFG_PAR_TYP = 1'b0;
        REQ0_DATA   = 8'h3C;
        push(8'h3C, 1'b0, 1'b0, 1'b0);
        REQ0_VALID  = 1'b1;
        wait_ready(1'b0, 10, "t4_ready0");
        tick();
        REQ0_VALID = 1'b0;
        check("t4_strobe", 32'(TX_DATA_VALID), 32'd1);
        repeat (BT) tick();
        check("t4_err_not_yet", 32'(ERR_TIMEOUT), 32'd0);
        tick();
        check("t4_err_set",    32'(ERR_TIMEOUT), 32'd1);
        check("t4_frame_cnt",  32'(FRAME_CNT),   32'd0);
        check("t4_idle_ready", 32'(REQ0_READY),  32'd1);
        model_en   = 1'b1;
        REQ1_DATA  = 8'h4D;
        push(8'h4D, 1'b0, 1'b0, 1'b1);
        REQ1_VALID = 1'b1;
        wait_ready(1'b1, 10, "t4_next_ready1");
        tick();
        REQ1_VALID = 1'b0;
        wait_cnt(3'd1, 40, "t4_next_frame");
        check("t4_err_sticky", 32'(ERR_TIMEOUT), 32'd1);

        // Reset in WAIT_DONE with busy held afterwards.
        REQ0_DATA  = 8'h99;
        push(8'h99, 1'b0, 1'b0, 1'b0);
        REQ0_VALID = 1'b1;
        wait_ready(1'b0, 10, "t5_ready0");
        tick();
        REQ0_VALID = 1'b0;
        repeat (4) tick();
        RST        = 1'b1;
        force_busy = 1'b1;
        model_en   = 1'b0;
        tick();
        RST        = 1'b0;
        check_all_zero("t5_post_rst");
        REQ0_DATA  = 8'hE1;
        REQ1_DATA  = 8'hE2;
        REQ0_VALID = 1'b1;
        REQ1_VALID = 1'b1;
        model_en   = 1'b1;
        push(8'hE1, 1'b0, 1'b0, 1'b0);
        push(8'hE2, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t5_blocked_ready0", 32'(REQ0_READY), 32'd0);
            check("t5_blocked_ready1", 32'(REQ1_READY), 32'd0);
            tick();
        end
        force_busy = 1'b0;
        #1;
        check("t5_ready0_first", 32'(REQ0_READY), 32'd1);
        base = n_strobe;
        wait_strobes(base + 1, 20, "t5_first_strobe");
        REQ0_VALID = 1'b0;
        wait_strobes(base + 2, 40, "t5_second_strobe");
        REQ1_VALID = 1'b0;
        wait_cnt(3'd2, 40, "t5_frame_cnt");

        // Counter wrap with a 3-bit counter: 1..7, 0, 1.
        pulse_reset();
        busy_len = 3;
        for (int i = 0; i < 9; i++) begin
            REQ0_DATA  = 8'(8'h40 + i);
            push(8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
            REQ0_VALID = 1'b1;
            wait_ready(1'b0, 10, "t6_ready0");
            tick();
            REQ0_VALID = 1'b0;
            wait_cnt(3'((i + 1) % 8), 30, "t6_frame_cnt");
        end

        repeat (3) tick();
        check("final_sb_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Two-requester scheduler for the UART transmit path. Arbitrates byte-transfer requests from two producers (round-robin) and sequences the transmitter's `P_DATA`/`Data_Valid` strobe against its `busy` flag. Latches per-frame parity configuration and counts completed frames. Flags a transmitter that never acknowledges a strobe. Sits between the system producers (register-file readback, ALU result path) and the UART transmitter.

## Interface
- `DATA_W`, 8, data byte width
- `CNT_W`, 16, width of completed-frame counter
- `BUSY_TIMEOUT`, 4, cycles allowed for `TX_BUSY` to rise after a strobe (≥2)

Ports:
- `CLK`  in  1  single clock, all state on rising edge
- `RST`  in  1  synchronous, active-high reset
- `REQ0_DATA`  in  DATA_W  requester 0 byte
- `REQ0_VALID`  in  1  requester 0 has a byte
- `REQ0_READY`  out  1  requester 0 byte accepted when VALID&READY
- `REQ1_DATA`  in  DATA_W  requester 1 byte
- `REQ1_VALID`  in  1  requester 1 has a byte
- `REQ1_READY`  out  1  requester 1 byte accepted when VALID&READY
- `CFG_PAR_EN`  in  1  parity enable, sampled at accept
- `CFG_PAR_TYP`  in  1  parity type, sampled at accept
- `TX_BUSY`  in  1  transmitter busy flag
- `TX_P_DATA`  out  DATA_W  byte to transmitter, registered
- `TX_DATA_VALID`  out  1  one-cycle strobe to transmitter, registered
- `TX_PAR_EN`  out  1  latched parity enable
- `TX_PAR_TYP`  out  1  latched parity type
- `GRANT_ID`  out  1  requester owning the current/last frame
- `FRAME_CNT`  out  CNT_W  completed frames, wraps
- `ERR_TIMEOUT`  out  1  sticky; transmitter failed to assert busy

## Operation
- States: IDLE, STROBE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - READY is combinational: `REQn_READY = (state==IDLE) & !TX_BUSY & (sel==n)`.
  - `sel` is the round-robin choice. If only one VALID, select it. If both, select the requester not equal to the last-granted pointer. Pointer resets to 1, so requester 0 wins the first contest.
  - READY never asserts for both requesters in the same cycle.
- Accept (VALID&READY in IDLE):
  - Latch DATA into `TX_P_DATA`.
  - Latch CFG into `TX_PAR_EN`/`TX_PAR_TYP`.
  - Set `GRANT_ID` and the pointer to `sel`.
  - Set `TX_DATA_VALID`=1 and go to STROBE.
- STROBE: `TX_DATA_VALID` is 1 for exactly this cycle. Next state is WAIT_BUSY with a timeout counter of 0.
- WAIT_BUSY:
  - `TX_BUSY`=1 → WAIT_DONE.
  - Otherwise the counter increments. When it reaches `BUSY_TIMEOUT`-1 with `TX_BUSY` still 0: set `ERR_TIMEOUT`, go to IDLE, no `FRAME_CNT` increment.
- WAIT_DONE: `TX_BUSY`=0 → IDLE and `FRAME_CNT` += 1, modulo 2^CNT_W (all-ones wraps to 0).
- `TX_P_DATA`, `TX_PAR_EN`, `TX_PAR_TYP` and `GRANT_ID` hold their values from accept until the next accept.
- `ERR_TIMEOUT` clears only on `RST`. Scheduling continues after an error.
- CFG changes after accept do not affect the frame in flight.

## Timing
- Reset values:
  - State IDLE; round-robin pointer 1.
  - `TX_P_DATA`, `TX_DATA_VALID`, `TX_PAR_EN`, `TX_PAR_TYP`, `GRANT_ID`, `FRAME_CNT` and `ERR_TIMEOUT` all 0.
  - Both READY outputs are 0 during the reset cycle.
- `RST` asserted in any state returns to IDLE next edge and drops `TX_DATA_VALID` immediately. The frame in flight is abandoned and not counted.
- Latency:
  - Accept at cycle T → `TX_DATA_VALID`=1 in cycle T+1.
  - Earliest `TX_BUSY` check is cycle T+2.
- Completion: `TX_BUSY` low sampled in cycle U (WAIT_DONE) → IDLE in U+1. READY can assert in U+1, so the next strobe comes at U+2 at the earliest.
- `TX_BUSY` high while in IDLE (e.g. after reset mid-frame) blocks all grants until it falls.
- A `TX_BUSY` pulse seen in WAIT_BUSY for a single cycle is enough. The falling edge in the following cycle completes the frame normally.
- Timeout: no busy in cycles T+2 … T+1+`BUSY_TIMEOUT` → `ERR_TIMEOUT`=1 and IDLE from T+2+`BUSY_TIMEOUT`.

## Test plan
- Single frame, parity on:
  - Stimulus: REQ0 0xA5 VALID, CFG_PAR_EN=1, CFG_PAR_TYP=1; model busy rises 1 cycle after strobe and lasts 11 cycles.
  - Response: REQ0_READY at accept; 1-cycle strobe with `TX_P_DATA`=0xA5 and TX_PAR_EN/TYP=1/1; `FRAME_CNT`=1; `GRANT_ID`=0.
- Round-robin contention:
  - Stimulus: both VALID continuously, REQ0=0x11, REQ1=0x22, 4 frames.
  - Response: transmitted sequence 0x11, 0x22, 0x11, 0x22; never both READY in one cycle; `FRAME_CNT`=4.
- Back-to-back gap:
  - Stimulus: REQ1 VALID held; busy falls in cycle U.
  - Response: next `TX_DATA_VALID` exactly at U+2; CFG change after accept does not alter the latched TX_PAR_EN.
- Timeout:
  - Stimulus: `TX_BUSY` tied 0, REQ0 0x3C.
  - Response: `ERR_TIMEOUT`=1 at strobe+1+`BUSY_TIMEOUT`; `FRAME_CNT` stays 0; next request is still accepted.
- Reset mid-frame:
  - Stimulus: `RST` during WAIT_DONE with `TX_BUSY`=1 held 3 more cycles.
  - Response: all outputs return to 0; no READY until `TX_BUSY`=0; requester 0 wins the first contest afterward.
- Counter wrap:
  - Stimulus: CNT_W=3, 9 frames.
  - Response: `FRAME_CNT` counts 1…7, 0, 1.
